// File: rtl/rom_read_master.sv
// AXI4 read-only master: turns single-cycle fetch requests into INCR bursts and
// buffers returned beats in a first-word-fall-through FIFO, flagging bad beats.
module rom_read_master #(
  parameter logic [3:0] MASTER_ID  = 4'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        busy,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARID_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      addr_reg;
  logic [3:0]       len_reg;
  logic [3:0]       beat_cnt_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [33:0]      fifo_mem [FIFO_DEPTH];
  logic [33:0]      head;

  logic req_hs, ar_hs, r_hs, pop;
  logic fifo_full, fifo_empty;
  logic beat_last, beat_err;

  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign fifo_empty = (count_reg == '0);

  assign req_ready = (state_reg == IDLE) && !ARESET;
  assign req_hs    = req_valid && req_ready;
  assign ar_hs     = ARVALID_M && ARREADY_M;
  assign r_hs      = RVALID_M && RREADY_M;
  assign pop       = rsp_valid && rsp_ready;

  assign beat_last = (beat_cnt_reg == len_reg);
  assign beat_err  = (RRESP_M != 2'b00) | (RID_M != MASTER_ID) | (RLAST_M != beat_last);

  assign ARVALID_M = (state_reg == ADDR);
  assign ARADDR_M  = addr_reg;
  assign ARLEN_M   = len_reg;
  assign ARID_M    = MASTER_ID;
  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  // Backpressure looks only at the registered count, so a same-cycle pop never frees a slot.
  assign RREADY_M  = (state_reg == DATA) && !fifo_full;

  assign head      = fifo_mem[rd_ptr_reg];
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = rsp_valid ? head[33:2] : 32'd0;
  assign rsp_last  = rsp_valid & head[1];
  assign rsp_err   = rsp_valid & head[0];
  assign busy      = (state_reg != IDLE) || !fifo_empty;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_hs) state_next = ADDR;
      ADDR:    if (ar_hs) state_next = DATA;
      DATA:    if (r_hs && (RLAST_M || beat_last)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_reg     <= 32'd0;
      len_reg      <= 4'd0;
      beat_cnt_reg <= 4'd0;
    end else if (req_hs) begin
      addr_reg     <= {req_addr[31:2], 2'b00};
      len_reg      <= req_len;
      beat_cnt_reg <= 4'd0;
    end else if (r_hs) begin
      beat_cnt_reg <= beat_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (r_hs) wr_ptr_reg <= wr_ptr_reg + (PTR_W)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W)'(1);
      case ({r_hs, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge ACLK) begin
    if (r_hs) fifo_mem[wr_ptr_reg] <= {RDATA_M, beat_last, beat_err};
  end

endmodule

// File: tb/tb_rom_read_master.sv
// Randomized scoreboard bench for rom_read_master with a behavioural AXI ROM slave
// and a burst-level expected-beat model.
module tb_rom_read_master;

  localparam logic [3:0] TB_ID = 4'd3;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [3:0]  req_len = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last, rsp_err, busy;
  logic        ARVALID_M;
  logic        ARREADY_M = 1'b0;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARID_M, ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        RVALID_M = 1'b0;
  logic        RREADY_M;
  logic [3:0]  RID_M = 4'd0;
  logic [31:0] RDATA_M = 32'd0;
  logic [1:0]  RRESP_M = 2'b00;
  logic        RLAST_M = 1'b0;

  rom_read_master #(.MASTER_ID(TB_ID), .FIFO_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M), .ARADDR_M(ARADDR_M), .ARID_M(ARID_M),
    .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .RID_M(RID_M), .RDATA_M(RDATA_M),
    .RRESP_M(RRESP_M), .RLAST_M(RLAST_M)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    int          mode;
    int          err_beat;
    bit          bad_id;
    int          early;
    int          stall;
  } cfg_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
  } beat_t;

  cfg_t  cfg_q[$];
  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int gap_pct = 0;
  int rr_mode = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Burst payload: 0 = address hash, 1 = beat index + 1, 2 = fixed pattern.
  function automatic logic [31:0] data_of(input int mode, input logic [31:0] a, input int i);
    logic [31:0] x;
    x = a + 32'(4 * i);
    case (mode)
      1:       return 32'(i + 1);
      2:       return 32'hDEAD_BEEF;
      default: return (x * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 32'(ARVALID_M), 32'd0);
    chk({tag, "_rready"}, 32'(RREADY_M), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_araddr"}, ARADDR_M, 32'd0);
    chk({tag, "_arlen"}, 32'(ARLEN_M), 32'd0);
    chk({tag, "_arid"}, 32'(ARID_M), 32'(TB_ID));
    chk({tag, "_arsize"}, 32'(ARSIZE_M), 32'd2);
    chk({tag, "_arburst"}, 32'(ARBURST_M), 32'd1);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Model: beats run until the slave's RLAST or beat len, whichever comes first;
  // rsp_last marks beat len, rsp_err marks bad RRESP, bad RID or a misplaced RLAST.
  task automatic issue_req(input logic [31:0] addr, input int len, input int mode,
                           input int err_beat, input bit bad_id, input int early, input int stall);
    cfg_t  c;
    beat_t b;
    int    nl;
    bit    ok;
    c.addr = {addr[31:2], 2'b00};
    c.len = 4'(len);
    c.mode = mode;
    c.err_beat = err_beat;
    c.bad_id = bad_id;
    c.early = early;
    c.stall = stall;
    nl = (early >= 0 && early < len) ? early : len;
    for (int i = 0; i <= nl; i++) begin
      b.d = data_of(mode, c.addr, i);
      b.l = (i == len);
      b.e = (i == err_beat) || bad_id || ((i == nl) != (i == len));
      exp_q.push_back(b);
    end
    cfg_q.push_back(c);
    req_valid = 1'b1;
    req_addr = addr;
    req_len = 4'(len);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge ACLK);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 300 cycles");
    end
    req_cyc = cyc;
    $display("req addr=%h len=%0d mode=%0d err_beat=%0d bad_id=%0b early=%0d stall=%0d",
             addr, len, mode, err_beat, bad_id, early, stall);
    @(posedge ACLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge ACLK);
      if (!busy && exp_q.size() == 0 && cfg_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done_timeout: got busy=%0b pending=%0d expected idle with 0 pending",
               tag, busy, exp_q.size());
    end
    @(posedge ACLK); #1;
  endtask

  // Requester ready: 0 = held low, 1 = held high, 2 = random.
  initial forever begin
    @(posedge ACLK); #1;
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(1));
    endcase
  end

  // Monitor: every popped head is compared against the oldest expected beat.
  initial forever begin
    beat_t e;
    @(negedge ACLK);
    if (!ARESET && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_rsp: got data=%h with nothing expected", rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_last", 32'(rsp_last), 32'(e.l));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
        $display("rsp data=%h last=%0b err=%0b", rsp_data, rsp_last, rsp_err);
      end
    end
  end

  // Behavioural AXI ROM slave.
  initial begin
    cfg_t        s_cfg;
    logic [31:0] s_addr;
    logic [31:0] prev_araddr;
    int          s_beat, s_last, ar_wait;
    bit          s_active, ar_hs_s, r_hs_s, rlast_s, arv_s, prev_arv;
    s_active = 1'b0;
    ar_wait = 0;
    prev_arv = 1'b0;
    s_beat = 0;
    s_last = 0;
    s_addr = 32'd0;
    prev_araddr = 32'd0;
    forever begin
      @(negedge ACLK);
      ar_hs_s = ARVALID_M && ARREADY_M;
      r_hs_s  = RVALID_M && RREADY_M;
      rlast_s = RLAST_M;
      arv_s   = ARVALID_M;
      if (prev_arv && !ARESET) begin
        chk("ar_hold_valid", 32'(ARVALID_M), 32'd1);
        chk("ar_hold_addr", ARADDR_M, prev_araddr);
      end
      prev_arv = ARVALID_M && !ARREADY_M && !ARESET;
      prev_araddr = ARADDR_M;
      if (ar_hs_s && !ARESET) begin
        if (cfg_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_ar: got araddr=%h with no request pending", ARADDR_M);
        end else begin
          s_cfg = cfg_q.pop_front();
          chk("araddr", ARADDR_M, s_cfg.addr);
          chk("arlen", 32'(ARLEN_M), 32'(s_cfg.len));
          s_addr = ARADDR_M;
          s_last = (s_cfg.early >= 0) ? s_cfg.early : int'(ARLEN_M);
          s_beat = 0;
        end
      end
      @(posedge ACLK); #2;
      if (ARESET) begin
        ARREADY_M = 1'b0;
        RVALID_M = 1'b0;
        RLAST_M = 1'b0;
        s_active = 1'b0;
        ar_wait = 0;
        prev_arv = 1'b0;
      end else begin
        if (r_hs_s) begin
          RVALID_M = 1'b0;
          if (rlast_s) s_active = 1'b0;
          else         s_beat++;
        end
        if (ar_hs_s) begin
          s_active = 1'b1;
          ar_wait = 0;
        end else if (arv_s) begin
          ar_wait++;
        end
        ARREADY_M = (cfg_q.size() > 0) && (ar_wait >= cfg_q[0].stall);
        if (s_active && !RVALID_M && $urandom_range(99) >= gap_pct) begin
          RDATA_M  = data_of(s_cfg.mode, s_addr, s_beat);
          RRESP_M  = (s_beat == s_cfg.err_beat) ? 2'b10 : 2'b00;
          RID_M    = s_cfg.bad_id ? 4'd5 : TB_ID;
          RLAST_M  = (s_beat == s_last);
          RVALID_M = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int t_last;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("por");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    @(posedge ACLK); #1;

    // Single beat with latency measurement.
    rr_mode = 1;
    gap_pct = 0;
    issue_req(32'h0000_0104, 0, 2, -1, 1'b0, -1, 0);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("first_rsp_seen", 32'(found), 32'd1);
    chk("req_to_rsp_latency", 32'(cyc - req_cyc), 32'd3);
    @(posedge ACLK); #1;
    wait_done("single");

    // Six beats against a held-off requester: FIFO fills and backpressures.
    rr_mode = 0;
    issue_req(32'h0000_1000, 5, 1, -1, 1'b0, -1, 0);
    repeat (20) @(posedge ACLK);
    @(negedge ACLK);
    chk("full_rready", 32'(RREADY_M), 32'd0);
    chk("full_rvalid_waiting", 32'(RVALID_M), 32'd1);
    chk("full_head", rsp_data, 32'd1);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    @(posedge ACLK); #1;
    rr_mode = 1;
    wait_done("backpressure");

    // Error flags: bad RRESP on beat 2, then a wrong RID burst.
    issue_req(32'h0000_2000, 2, 0, 1, 1'b0, -1, 0);
    issue_req(32'h0000_3000, 1, 0, -1, 1'b1, -1, 0);
    wait_done("errors");

    // Early RLAST on beat 2 of 4.
    issue_req(32'h0000_4000, 3, 0, -1, 1'b0, 1, 0);
    found = 1'b0;
    t_last = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge ACLK);
      if (RVALID_M && RREADY_M && RLAST_M) begin
        found = 1'b1;
        t_last = cyc;
        break;
      end
    end
    chk("early_rlast_seen", 32'(found), 32'd1);
    @(negedge ACLK);
    chk("early_req_ready", 32'(req_ready), 32'd1);
    chk("early_cycle", 32'(cyc - t_last), 32'd1);
    @(posedge ACLK); #1;
    wait_done("early");

    // ARREADY stall; the slave checks ARVALID/ARADDR hold every stalled cycle.
    issue_req(32'h0000_5006, 1, 0, -1, 1'b0, -1, 5);
    wait_done("stall");

    // Reset after the first of four beats is buffered.
    rr_mode = 0;
    issue_req(32'h0000_6000, 3, 1, -1, 1'b0, -1, 0);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge ACLK);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("pre_reset_beat", 32'(found), 32'd1);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    exp_q.delete();
    cfg_q.delete();
    @(negedge ACLK);
    check_reset_outputs("midrst");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    rr_mode = 1;
    issue_req(32'h0000_7000, 2, 0, -1, 1'b0, -1, 0);
    wait_done("after_reset");

    // Randomized traffic with gaps, stalls, random requester ready and injected faults.
    rr_mode = 2;
    gap_pct = 30;
    for (int n = 0; n < 40; n++) begin
      int len, eb, ea;
      bit bid;
      len = $urandom_range(15);
      eb  = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
      bid = ($urandom_range(9) == 0);
      ea  = (len > 0 && $urandom_range(9) == 0) ? int'($urandom_range(len - 1)) : -1;
      issue_req($urandom, len, 0, eb, bid, ea, $urandom_range(3));
    end
    wait_done("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
